inst_reload_ctrl: RTL and testbench
===================================

// Module: inst_reload_ctrl
// PURPOSE
//  Responder side of the SERIAL_CPU_8BIT nxt/start handshake. Launches the CPU on a host go pulse,
//  watches nxt; on nxt[1] (instruction block exhausted) takes the shared 8-bit memory port.
//  Streams a new little-endian 16-bit instruction block from a host byte stream into the
//  instruction area at BASE_ADDR, then re-pulses start. On nxt[0] (HALT) parks and flags halted.
// PARAMETERS
//  ADDR_W     9    memory byte-address width (matches I_MEMORY_8BIT addr)
//  BASE_ADDR  500  first byte address of reload area (= DEFAULT_PC_ADDR*2)
//  MAX_BYTES  64   largest accepted block in bytes; must be even, 2..2^ADDR_W
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  go         in   1       host pulse: first CPU launch (honoured in IDLE only)
//  nxt        in   2       from CPU: [1]=reload request, [0]=program halted
//  s_valid    in   1       host byte stream valid
//  s_data     in   8       host byte (even index = instr[7:0], odd = instr[15:8])
//  s_last     in   1       qualifies final byte of block
//  s_ready    out  1       loader accepts byte this cycle
//  mem_grant  out  1       1 = loader owns memory port (external mux selects mem_* over CPU)
//  mem_we     out  1       registered write strobe
//  mem_addr   out  ADDR_W  registered write address
//  mem_wdata  out  8       registered write data
//  cpu_start  out  1       one-cycle start pulse to CPU
//  halted     out  1       sticky: CPU reported nxt[0]
//  err        out  1       sticky: block exceeded MAX_BYTES
//  reload_cnt out  8       completed reloads, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; byte counter 0; rearm flag 0.
//  States: IDLE, RUN, LOAD, PAD, START, HALT, ERR.
//  IDLE: go -> START. nxt ignored.
//  START: cpu_start=1 exactly one cycle, mem_grant=0; next RUN with rearm=0.
//  RUN: rearm set on first cycle nxt==2'b00 (masks stale nxt after start). While rearm=1:
//   nxt[0] -> HALT (priority over nxt[1] if both set); else nxt[1] -> LOAD, cnt=0.
//  LOAD: mem_grant=1, s_ready=1. Handshake (s_valid&s_ready) at cycle N -> cycle N+1:
//   mem_we=1, mem_addr=(BASE_ADDR+cnt) mod 2^ADDR_W, mem_wdata=s_data; cnt+=1.
//   s_last on even cnt (odd byte count) -> PAD; s_last on odd cnt -> START, reload_cnt+=1.
//   Accepted byte with cnt==MAX_BYTES-1 and no s_last -> ERR (that byte still written).
//   s_valid=0: hold, no write, no timeout.
//  PAD: s_ready=0; one write of 0x00 at BASE_ADDR+cnt; then START, reload_cnt+=1.
//  HALT: halted=1, mem_grant=0, s_ready=0; leaves only on rst.
//  ERR: err=1, mem_grant=0, s_ready=0, no cpu_start; leaves only on rst.
//  mem_grant drops in the START cycle; last write strobe lands at or before that cycle.
//  Write latency: 1 cycle handshake->mem_we. Throughput: 1 byte/cycle.
//  Reset mid-LOAD: abandon block, no start pulse; partially written bytes stay in memory.
//  go outside IDLE ignored; s_* outside LOAD ignored (s_ready=0).
// STRUCTURE
//  Shared cpu_defs package/include: state encoding, BASE_ADDR default (DEFAULT_PC_ADDR*2),
//   nxt bit indices (NXT_RELOAD=1, NXT_HALT=0).
//  One FSM + counter + output registers in a single module; no sub-module needed.
// TESTING
//  T1 reset: rst=1 2 cycles -> all outputs 0, state IDLE; go during rst ignored.
//  T2 launch: go pulse -> cpu_start high exactly 1 cycle, next cycle; mem_grant=0.
//  T3 reload 8 bytes {LOAD,ADD,STORE,HALT} back-to-back, nxt=2'b10 -> writes addr 500..507
//   one per cycle, data in order, then one cpu_start; reload_cnt=1; grant low after.
//  T4 odd block 3 bytes A1,B2,C3 with s_valid gaps -> 500=A1,501=B2,502=C3,503=00; start once.
//  T5 nxt=2'b11 in RUN -> HALT, halted=1, no grant, no start; stale nxt right after start
//   (nxt held 2'b10 through START) must not retrigger LOAD until nxt seen 00.
//  T6 overflow: MAX_BYTES=4, 5 bytes no s_last -> bytes 0..3 written, err=1, s_ready=0, no start;
//   BASE_ADDR=510 variant with 4 bytes -> writes 510,511,0,1 (wrap).

Source files
------------

// File: rtl/inst_reload_ctrl_pkg.sv
// Shared definitions for the SERIAL_CPU_8BIT instruction reload controller:
// FSM encoding, reload area default and nxt bit positions.
package inst_reload_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PAD   = 3'd3,
        ST_START = 3'd4,
        ST_HALT  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam int DEFAULT_PC_ADDR   = 250;
    localparam int BASE_ADDR_DEFAULT = DEFAULT_PC_ADDR * 2;
    localparam int NXT_RELOAD        = 1;
    localparam int NXT_HALT          = 0;

    // Reload counter stops at 255 instead of wrapping back to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

endpackage

// File: rtl/inst_reload_ctrl.sv
// Responder for the CPU nxt/start handshake: launches the CPU, reloads the
// instruction area from a host byte stream on request, and parks on HALT.
module inst_reload_ctrl
    import inst_reload_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int MAX_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [1:0]        nxt,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_grant,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_start,
    output logic              halted,
    output logic              err,
    output logic [7:0]        reload_cnt
);

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(MAX_BYTES - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              rearm_r;
    logic              hs_s;

    assign hs_s = s_valid && s_ready;

    // FSM, byte counter and all registered outputs; write strobe and start are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {ADDR_W{1'b0}};
            rearm_r    <= 1'b0;
            s_ready    <= 1'b0;
            mem_grant  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wdata  <= 8'h00;
            cpu_start  <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
            reload_cnt <= 8'h00;
        end else begin
            mem_we    <= 1'b0;
            cpu_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (go) begin
                        state_r   <= ST_START;
                        cpu_start <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    state_r <= ST_RUN;
                    rearm_r <= 1'b0;
                end
                ST_RUN: begin
                    // nxt is still stale from the previous program until it reads 00 once.
                    if (!rearm_r) begin
                        if (nxt == 2'b00) begin
                            rearm_r <= 1'b1;
                        end else begin
                            rearm_r <= 1'b0;
                        end
                    end else if (nxt[NXT_HALT]) begin
                        state_r <= ST_HALT;
                        halted  <= 1'b1;
                    end else if (nxt[NXT_RELOAD]) begin
                        state_r   <= ST_LOAD;
                        cnt_r     <= {ADDR_W{1'b0}};
                        mem_grant <= 1'b1;
                        s_ready   <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (hs_s) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_A + cnt_r;
                        mem_wdata <= s_data;
                        cnt_r     <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (s_last && !cnt_r[0]) begin
                            state_r <= ST_PAD;
                            s_ready <= 1'b0;
                        end else if (s_last) begin
                            state_r    <= ST_START;
                            cpu_start  <= 1'b1;
                            mem_grant  <= 1'b0;
                            s_ready    <= 1'b0;
                            reload_cnt <= sat_inc8(reload_cnt);
                        end else if (cnt_r == LAST_CNT) begin
                            state_r   <= ST_ERR;
                            err       <= 1'b1;
                            mem_grant <= 1'b0;
                            s_ready   <= 1'b0;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_PAD: begin
                    // Odd-length block: complete the final 16-bit word with a zero high byte.
                    mem_we     <= 1'b1;
                    mem_addr   <= BASE_A + cnt_r;
                    mem_wdata  <= 8'h00;
                    state_r    <= ST_START;
                    cpu_start  <= 1'b1;
                    mem_grant  <= 1'b0;
                    reload_cnt <= sat_inc8(reload_cnt);
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                ST_ERR: begin
                    state_r <= ST_ERR;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_grant <= 1'b0;
                    s_ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_reload_ctrl.sv
// Scoreboard bench for inst_reload_ctrl: three instances (default, MAX_BYTES=4,
// BASE_ADDR=510) driven in turn; writes and start pulses are checked by a monitor.
module tb_inst_reload_ctrl;

    typedef struct packed {
        logic [1:0] inst;
        logic       is_start;
        logic [8:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go_s      [3];
    logic [1:0] nxt_s     [3];
    logic       s_valid_s [3];
    logic [7:0] s_data_s  [3];
    logic       s_last_s  [3];
    logic       s_ready_s    [3];
    logic       mem_grant_s  [3];
    logic       mem_we_s     [3];
    logic [8:0] mem_addr_s   [3];
    logic [7:0] mem_wdata_s  [3];
    logic       cpu_start_s  [3];
    logic       halted_s     [3];
    logic       err_s        [3];
    logic [7:0] reload_cnt_s [3];

    ev_t exp_q [$];
    int  n_pass  = 0;
    int  n_total = 0;

    always #5 clk = ~clk;

    inst_reload_ctrl u_main (
        .clk(clk), .rst(rst), .go(go_s[0]), .nxt(nxt_s[0]),
        .s_valid(s_valid_s[0]), .s_data(s_data_s[0]), .s_last(s_last_s[0]),
        .s_ready(s_ready_s[0]), .mem_grant(mem_grant_s[0]), .mem_we(mem_we_s[0]),
        .mem_addr(mem_addr_s[0]), .mem_wdata(mem_wdata_s[0]), .cpu_start(cpu_start_s[0]),
        .halted(halted_s[0]), .err(err_s[0]), .reload_cnt(reload_cnt_s[0])
    );

    inst_reload_ctrl #(.MAX_BYTES(4)) u_ovf (
        .clk(clk), .rst(rst), .go(go_s[1]), .nxt(nxt_s[1]),
        .s_valid(s_valid_s[1]), .s_data(s_data_s[1]), .s_last(s_last_s[1]),
        .s_ready(s_ready_s[1]), .mem_grant(mem_grant_s[1]), .mem_we(mem_we_s[1]),
        .mem_addr(mem_addr_s[1]), .mem_wdata(mem_wdata_s[1]), .cpu_start(cpu_start_s[1]),
        .halted(halted_s[1]), .err(err_s[1]), .reload_cnt(reload_cnt_s[1])
    );

    inst_reload_ctrl #(.BASE_ADDR(510)) u_wrap (
        .clk(clk), .rst(rst), .go(go_s[2]), .nxt(nxt_s[2]),
        .s_valid(s_valid_s[2]), .s_data(s_data_s[2]), .s_last(s_last_s[2]),
        .s_ready(s_ready_s[2]), .mem_grant(mem_grant_s[2]), .mem_we(mem_we_s[2]),
        .mem_addr(mem_addr_s[2]), .mem_wdata(mem_wdata_s[2]), .cpu_start(cpu_start_s[2]),
        .halted(halted_s[2]), .err(err_s[2]), .reload_cnt(reload_cnt_s[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_wr(input int k, input int a, input logic [7:0] d);
        exp_q.push_back('{inst: 2'(k), is_start: 1'b0, addr: 9'(a), data: d});
    endtask

    task automatic push_start(input int k);
        exp_q.push_back('{inst: 2'(k), is_start: 1'b1, addr: 9'd0, data: 8'h00});
    endtask

    task automatic check_ev(input int k, input logic st, input logic [8:0] a, input logic [7:0] d);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL event inst%0d: got start=%0b addr=%0d data=%02h, expected no event",
                     k, st, a, d);
        end else begin
            e = exp_q.pop_front();
            if (int'(e.inst) == k && e.is_start == st && e.addr == a && e.data == d) n_pass++;
            else $display("FAIL event inst%0d: got start=%0b addr=%0d data=%02h, expected inst%0d start=%0b addr=%0d data=%02h",
                          k, st, a, d, e.inst, e.is_start, e.addr, e.data);
        end
    endtask

    task automatic send_byte(input int k, input logic [7:0] d, input logic last, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            s_valid_s[k] = 1'b0;
            tick();
        end
        s_valid_s[k] = 1'b1;
        s_data_s[k]  = d;
        s_last_s[k]  = last;
        tick();
        s_valid_s[k] = 1'b0;
        s_last_s[k]  = 1'b0;
    endtask

    // Launch instance k from IDLE and bring it to LOAD with nxt=10.
    task automatic launch_and_request(input int k);
        push_start(k);
        go_s[k] = 1'b1;
        tick();
        go_s[k] = 1'b0;
        tick();
        tick();
        nxt_s[k] = 2'b10;
        tick();
    endtask

    // Monitor: every write strobe and start pulse must match the scoreboard head.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_we_s[k] === 1'b1) check_ev(k, 1'b0, mem_addr_s[k], mem_wdata_s[k]);
            if (cpu_start_s[k] === 1'b1) check_ev(k, 1'b1, 9'd0, 8'h00);
        end
    end

    initial begin
        logic [7:0] blk [8];
        blk = '{8'h34, 8'h12, 8'h05, 8'h2A, 8'h07, 8'h3C, 8'h00, 8'hF0};
        for (int k = 0; k < 3; k++) begin
            go_s[k] = 1'b0; nxt_s[k] = 2'b00; s_valid_s[k] = 1'b0;
            s_data_s[k] = 8'h00; s_last_s[k] = 1'b0;
        end

        // T1: reset, with go asserted during reset
        rst = 1'b1;
        go_s[0] = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_outputs_inst%0d", k),
                {1'b0, s_ready_s[k], mem_grant_s[k], mem_we_s[k], cpu_start_s[k], halted_s[k],
                 err_s[k], reload_cnt_s[k], mem_addr_s[k], mem_wdata_s[k]}, 32'd0);
        rst = 1'b0;
        go_s[0] = 1'b0;
        tick();
        tick();
        chk("go_in_reset_ignored", {31'd0, cpu_start_s[0]}, 32'd0);

        // T2: launch
        push_start(0);
        go_s[0] = 1'b1;
        tick();
        go_s[0] = 1'b0;
        chk("launch_start_high", {31'd0, cpu_start_s[0]}, 32'd1);
        chk("launch_grant_low", {31'd0, mem_grant_s[0]}, 32'd0);
        tick();
        chk("launch_start_one_cycle", {31'd0, cpu_start_s[0]}, 32'd0);
        tick();
        nxt_s[0] = 2'b10;
        tick();
        chk("load_grant", {31'd0, mem_grant_s[0]}, 32'd1);
        chk("load_ready", {31'd0, s_ready_s[0]}, 32'd1);

        // T3: 8-byte block back to back
        for (int i = 0; i < 8; i++) push_wr(0, 500 + i, blk[i]);
        push_start(0);
        for (int i = 0; i < 8; i++) begin
            s_valid_s[0] = 1'b1;
            s_data_s[0]  = blk[i];
            s_last_s[0]  = (i == 7);
            tick();
        end
        s_valid_s[0] = 1'b0;
        s_last_s[0]  = 1'b0;
        nxt_s[0]     = 2'b00;
        chk("t3_grant_in_start", {31'd0, mem_grant_s[0]}, 32'd0);
        tick();
        tick();
        chk("t3_reload_cnt", {24'd0, reload_cnt_s[0]}, 32'd1);

        // T4: odd 3-byte block with gaps, padded with 00 at 503
        nxt_s[0] = 2'b10;
        tick();
        push_wr(0, 500, 8'hA1);
        push_wr(0, 501, 8'hB2);
        push_wr(0, 502, 8'hC3);
        push_wr(0, 503, 8'h00);
        push_start(0);
        send_byte(0, 8'hA1, 1'b0, 0);
        send_byte(0, 8'hB2, 1'b0, 2);
        send_byte(0, 8'hC3, 1'b1, 1);
        chk("t4_pad_ready_low", {31'd0, s_ready_s[0]}, 32'd0);
        chk("t4_pad_grant_high", {31'd0, mem_grant_s[0]}, 32'd1);
        nxt_s[0] = 2'b00;
        tick();
        tick();
        tick();
        chk("t4_reload_cnt", {24'd0, reload_cnt_s[0]}, 32'd2);

        // T5: stale nxt=10 held through START must not retrigger; then 11 halts
        nxt_s[0] = 2'b10;
        tick();
        push_wr(0, 500, 8'h5A);
        push_wr(0, 501, 8'hA5);
        push_start(0);
        send_byte(0, 8'h5A, 1'b0, 0);
        send_byte(0, 8'hA5, 1'b1, 0);
        repeat (4) tick();
        chk("t5_stale_no_grant", {31'd0, mem_grant_s[0]}, 32'd0);
        chk("t5_stale_no_ready", {31'd0, s_ready_s[0]}, 32'd0);
        nxt_s[0] = 2'b00;
        tick();
        nxt_s[0] = 2'b11;
        tick();
        chk("t5_halted", {31'd0, halted_s[0]}, 32'd1);
        chk("t5_halt_grant_ready",
            {30'd0, mem_grant_s[0], s_ready_s[0]}, 32'd0);
        chk("t5_reload_cnt", {24'd0, reload_cnt_s[0]}, 32'd3);
        nxt_s[0] = 2'b00;
        repeat (3) tick();
        chk("t5_halted_sticky", {31'd0, halted_s[0]}, 32'd1);

        // T6a: overflow with MAX_BYTES=4, five bytes and no s_last
        launch_and_request(1);
        push_wr(1, 500, 8'h11);
        push_wr(1, 501, 8'h22);
        push_wr(1, 502, 8'h33);
        push_wr(1, 503, 8'h44);
        for (int i = 0; i < 5; i++) begin
            s_valid_s[1] = 1'b1;
            s_data_s[1]  = 8'(8'h11 * (i + 1));
            s_last_s[1]  = 1'b0;
            tick();
            if (i == 3) chk("t6_ovf_ready_low", {31'd0, s_ready_s[1]}, 32'd0);
        end
        s_valid_s[1] = 1'b0;
        nxt_s[1]     = 2'b00;
        tick();
        chk("t6_ovf_err", {31'd0, err_s[1]}, 32'd1);
        chk("t6_ovf_grant_low", {31'd0, mem_grant_s[1]}, 32'd0);
        chk("t6_ovf_reload_cnt", {24'd0, reload_cnt_s[1]}, 32'd0);

        // T6b: BASE_ADDR=510, four bytes wrap to 0 and 1
        launch_and_request(2);
        push_wr(2, 510, 8'hC1);
        push_wr(2, 511, 8'hC2);
        push_wr(2, 0,   8'hC3);
        push_wr(2, 1,   8'hC4);
        push_start(2);
        send_byte(2, 8'hC1, 1'b0, 0);
        send_byte(2, 8'hC2, 1'b0, 0);
        send_byte(2, 8'hC3, 1'b0, 0);
        send_byte(2, 8'hC4, 1'b1, 0);
        nxt_s[2] = 2'b00;
        tick();
        tick();
        chk("t6_wrap_reload_cnt", {24'd0, reload_cnt_s[2]}, 32'd1);
        chk("t6_wrap_no_err", {31'd0, err_s[2]}, 32'd0);

        repeat (4) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
